// File: rtl/uart_rx_vote_sampler.sv
// Majority-vote bit sampler for the UART receiver: takes NUM_SAMPLES samples of RX_IN
// centred on each bit period and reports the voted bit, a noise flag and a config error.
module uart_rx_vote_sampler #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int NUM_SAMPLES    = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic                      sampled_bit,
    output logic                      sample_valid,
    output logic                      noise_flag,
    output logic                      cfg_err
);

    localparam int HALF = (NUM_SAMPLES - 1) / 2;
    localparam int CW   = $clog2(NUM_SAMPLES + 1);
    // Extra headroom so that none of the window sums below can wrap.
    localparam int EW   = PRESCALE_WIDTH + 4;

    localparam logic [EW-1:0] HALF_X = EW'(HALF);
    localparam logic [CW-1:0] N_C    = CW'(NUM_SAMPLES);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);

    if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > 7) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_num_samples
        $error("uart_rx_vote_sampler: NUM_SAMPLES must be odd and in 1..7");
    end

    logic [EW-1:0] pre_x;
    logic [EW-1:0] edge_x;
    logic [EW-1:0] center_x;
    logic          in_window;
    logic          at_decide;
    logic          at_last;

    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] taken_cnt;
    logic          first_val;
    logic          mismatch;

    // Lower window bound is tested as edge+HALF >= center to avoid subtracting below zero.
    always_comb begin
        pre_x     = EW'(Prescale);
        edge_x    = EW'(edge_cnt);
        center_x  = pre_x >> 1;
        cfg_err   = Prescale[0] | ((center_x + HALF_X + EW'(3)) > pre_x);
        in_window = ((edge_x + HALF_X) >= center_x) && (edge_x <= (center_x + HALF_X));
        at_decide = (edge_x + EW'(2)) == pre_x;
        at_last   = (edge_x + EW'(1)) == pre_x;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sampled_bit  <= 1'b0;
            sample_valid <= 1'b0;
            noise_flag   <= 1'b0;
            ones_cnt     <= '0;
            taken_cnt    <= '0;
            first_val    <= 1'b0;
            mismatch     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!enable || cfg_err || at_last) begin
                ones_cnt  <= '0;
                taken_cnt <= '0;
                first_val <= 1'b0;
                mismatch  <= 1'b0;
            end else begin
                // A partial window (enable rose mid-bit) leaves taken_cnt short and skips the decision.
                if (at_decide && (taken_cnt == N_C)) begin
                    sampled_bit  <= (ones_cnt > HALF_C);
                    noise_flag   <= mismatch;
                    sample_valid <= 1'b1;
                end
                if (in_window) begin
                    ones_cnt  <= ones_cnt + CW'(RX_IN);
                    taken_cnt <= taken_cnt + CW'(1);
                    if (taken_cnt == '0) begin
                        first_val <= RX_IN;
                        mismatch  <= 1'b0;
                    end else begin
                        mismatch <= mismatch | (RX_IN != first_val);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Self-checking bench: three sampler instances (N=3,5,7) share one stimulus stream and are
// compared against a per-bit-period vote model computed from the sample window rules.
module tb_uart_rx_vote_sampler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       enable;
    logic [5:0] Prescale;
    logic [5:0] edge_cnt;

    wire [2:0] sv;
    wire [2:0] sb;
    wire [2:0] nf;
    wire [2:0] ce;

    int   total  = 0;
    int   passed = 0;
    logic [2:0] exp_b = '0;
    logic [2:0] exp_n = '0;
    int   pulses[3];

    always #5 CLK = ~CLK;

    uart_rx_vote_sampler #(.PRESCALE_WIDTH(6), .NUM_SAMPLES(3)) dut3 (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .enable(enable), .Prescale(Prescale),
        .edge_cnt(edge_cnt), .sampled_bit(sb[0]), .sample_valid(sv[0]),
        .noise_flag(nf[0]), .cfg_err(ce[0]));

    uart_rx_vote_sampler #(.PRESCALE_WIDTH(6), .NUM_SAMPLES(5)) dut5 (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .enable(enable), .Prescale(Prescale),
        .edge_cnt(edge_cnt), .sampled_bit(sb[1]), .sample_valid(sv[1]),
        .noise_flag(nf[1]), .cfg_err(ce[1]));

    uart_rx_vote_sampler #(.PRESCALE_WIDTH(6), .NUM_SAMPLES(7)) dut7 (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .enable(enable), .Prescale(Prescale),
        .edge_cnt(edge_cnt), .sampled_bit(sb[2]), .sample_valid(sv[2]),
        .noise_flag(nf[2]), .cfg_err(ce[2]));

    // One bit period: vote over the centred window, valid only if enable covers window..decision.
    task automatic model(input int p, input logic [63:0] rx, input logic [63:0] en, input int n,
                         output logic v, output logic b, output logic nz, output logic err);
        int half = (n - 1) / 2;
        int c    = p / 2;
        int ones = 0;
        err = (p % 2 == 1) || (c + half > p - 3);
        v   = !err;
        b   = 1'b0;
        nz  = 1'b0;
        if (!err) begin
            for (int e = c - half; e <= c + half; e++) ones += int'(rx[e]);
            for (int e = c - half; e <= p - 2; e++) if (!en[e]) v = 1'b0;
            b  = ones > half;
            nz = (ones != 0) && (ones != n);
        end
    endtask

    task automatic drive_bit(input int p, input logic [63:0] rx, input logic [63:0] en);
        logic [2:0] v, b, nz, err;
        logic       exp_sv;
        for (int k = 0; k < 3; k++) model(p, rx, en, 3 + 2 * k, v[k], b[k], nz[k], err[k]);
        for (int e = 0; e < p; e++) begin
            edge_cnt = 6'(e);
            RX_IN    = rx[e];
            enable   = en[e];
            @(posedge CLK);
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_sv = (e == p - 2) && v[k];
                if (exp_sv) begin
                    exp_b[k] = b[k];
                    exp_n[k] = nz[k];
                end
                if (sv[k] === 1'b1) pulses[k]++;
                total++;
                if (sv[k] !== exp_sv)
                    $display("[TB] FAIL sample_valid N=%0d P=%0d edge=%0d got=%b want=%b", 3 + 2 * k, p, e, sv[k], exp_sv);
                else passed++;
                total++;
                if (sb[k] !== exp_b[k])
                    $display("[TB] FAIL sampled_bit N=%0d P=%0d edge=%0d got=%b want=%b", 3 + 2 * k, p, e, sb[k], exp_b[k]);
                else passed++;
                total++;
                if (nf[k] !== exp_n[k])
                    $display("[TB] FAIL noise_flag N=%0d P=%0d edge=%0d got=%b want=%b", 3 + 2 * k, p, e, nf[k], exp_n[k]);
                else passed++;
                total++;
                if (ce[k] !== err[k])
                    $display("[TB] FAIL cfg_err N=%0d P=%0d got=%b want=%b", 3 + 2 * k, p, ce[k], err[k]);
                else passed++;
            end
        end
    endtask

    task automatic set_prescale(input int p);
        enable   = 1'b0;
        edge_cnt = 6'd0;
        Prescale = 6'(p);
        @(posedge CLK);
        #1;
        total++;
        if (sv !== 3'b000) $display("[TB] FAIL idle_valid P=%0d got=%b want=000", p, sv);
        else passed++;
    endtask

    task automatic test_reset();
        RST = 1'b0; enable = 1'b0; RX_IN = 1'b0; edge_cnt = 6'd0; Prescale = 6'd8;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({sv, sb, nf} !== 9'b0) $display("[TB] FAIL reset_outputs got=%b want=0", {sv, sb, nf});
        else passed++;
        total++;
        if (ce !== 3'b110) $display("[TB] FAIL reset_cfg_err got=%b want=110", ce);
        else passed++;
        RST = 1'b1;
        exp_b = '0; exp_n = '0;
        for (int k = 0; k < 3; k++) pulses[k] = 0;
    endtask

    task automatic test_majority_p8();
        logic [63:0] rx = '0;
        set_prescale(8);
        rx[3] = 1'b1; rx[4] = 1'b0; rx[5] = 1'b1;
        pulses[0] = 0;
        drive_bit(8, rx, '1);
        total++;
        if (pulses[0] != 1 || sb[0] !== 1'b1 || nf[0] !== 1'b1)
            $display("[TB] FAIL n3_p8_vote pulses=%0d bit=%b noise=%b want 1/1/1", pulses[0], sb[0], nf[0]);
        else passed++;
    endtask

    task automatic test_n5_p16();
        logic [63:0] rx = '1;
        set_prescale(16);
        for (int e = 6; e <= 10; e++) rx[e] = 1'b0;
        pulses[1] = 0;
        drive_bit(16, rx, '1);
        total++;
        if (pulses[1] != 1 || sb[1] !== 1'b0 || nf[1] !== 1'b0)
            $display("[TB] FAIL n5_clean pulses=%0d bit=%b noise=%b want 1/0/0", pulses[1], sb[1], nf[1]);
        else passed++;
        rx = '0; rx[6] = 1'b1; rx[7] = 1'b1;
        drive_bit(16, rx, '1);
        total++;
        if (sb[1] !== 1'b0 || nf[1] !== 1'b1)
            $display("[TB] FAIL n5_noisy bit=%b noise=%b want 0/1", sb[1], nf[1]);
        else passed++;
    endtask

    task automatic test_cfg_err();
        logic [63:0] rx;
        set_prescale(8);
        total++;
        if (ce[2] !== 1'b1) $display("[TB] FAIL n7_p8_cfg_err got=%b want=1", ce[2]);
        else passed++;
        pulses[2] = 0;
        for (int i = 0; i < 10; i++) drive_bit(8, {$urandom, $urandom}, '1);
        total++;
        if (pulses[2] != 0) $display("[TB] FAIL n7_p8_no_pulse got=%0d want=0", pulses[2]);
        else passed++;
        set_prescale(32);
        total++;
        if (ce[2] !== 1'b0) $display("[TB] FAIL n7_p32_cfg_err got=%b want=0", ce[2]);
        else passed++;
        rx = '0;
        for (int e = 13; e <= 19; e++) rx[e] = 1'b1;
        drive_bit(32, rx, '1);
        total++;
        if (sb[2] !== 1'b1 || nf[2] !== 1'b0) $display("[TB] FAIL n7_window_in bit=%b noise=%b want 1/0", sb[2], nf[2]);
        else passed++;
        rx = '0; rx[12] = 1'b1; rx[20] = 1'b1;
        drive_bit(32, rx, '1);
        total++;
        if (sb[2] !== 1'b0 || nf[2] !== 1'b0) $display("[TB] FAIL n7_window_edges bit=%b noise=%b want 0/0", sb[2], nf[2]);
        else passed++;
        set_prescale(9);
        total++;
        if (ce !== 3'b111) $display("[TB] FAIL p9_cfg_err got=%b want=111", ce);
        else passed++;
        drive_bit(9, '1, '1);
    endtask

    task automatic test_enable_drop();
        logic [63:0] en = '1;
        set_prescale(8);
        drive_bit(8, '1, '1);
        en[4] = 1'b0; en[5] = 1'b0;
        pulses[0] = 0;
        drive_bit(8, '0, en);
        total++;
        if (pulses[0] != 0 || sb[0] !== 1'b1)
            $display("[TB] FAIL enable_drop pulses=%0d bit=%b want 0/1", pulses[0], sb[0]);
        else passed++;
        drive_bit(8, '0, '1);
        total++;
        if (pulses[0] != 1 || sb[0] !== 1'b0)
            $display("[TB] FAIL after_drop pulses=%0d bit=%b want 1/0", pulses[0], sb[0]);
        else passed++;
    endtask

    task automatic test_reset_midbit();
        logic [63:0] rx = '0;
        drive_bit(8, '1, '1);
        for (int e = 0; e <= 4; e++) begin
            edge_cnt = 6'(e); RX_IN = 1'b1; enable = 1'b1;
            @(posedge CLK);
            #1;
            total++;
            if (sv !== 3'b000) $display("[TB] FAIL pre_reset_valid edge=%0d got=%b want=000", e, sv);
            else passed++;
        end
        edge_cnt = 6'd5;
        RST = 1'b0;
        #1;
        total++;
        if ({sv, sb, nf} !== 9'b0) $display("[TB] FAIL midbit_reset got=%b want=0", {sv, sb, nf});
        else passed++;
        exp_b = '0; exp_n = '0;
        pulses[0] = 0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        for (int e = 6; e <= 7; e++) begin
            edge_cnt = 6'(e);
            @(posedge CLK);
            #1;
            total++;
            if (sv !== 3'b000) $display("[TB] FAIL post_reset_valid edge=%0d got=%b want=000", e, sv);
            else passed++;
        end
        rx[4] = 1'b1; rx[5] = 1'b1;
        drive_bit(8, rx, '1);
        total++;
        if (pulses[0] != 1 || sb[0] !== 1'b1 || nf[0] !== 1'b1)
            $display("[TB] FAIL first_after_reset pulses=%0d bit=%b noise=%b want 1/1/1", pulses[0], sb[0], nf[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] frame = {1'b1, 8'h2D, 1'b0};
        set_prescale(16);
        pulses[0] = 0;
        for (int i = 0; i < 10; i++) begin
            drive_bit(16, {64{frame[i]}}, '1);
            total++;
            if (sb[0] !== frame[i]) $display("[TB] FAIL frame_bit%0d got=%b want=%b", i, sb[0], frame[i]);
            else passed++;
        end
        total++;
        if (pulses[0] != 10) $display("[TB] FAIL frame_pulses got=%0d want=10", pulses[0]);
        else passed++;
    endtask

    task automatic test_random();
        int plist[13] = '{6, 8, 10, 12, 14, 16, 20, 24, 32, 40, 62, 7, 9};
        int p = 8;
        logic [63:0] en;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) begin
                p = plist[$urandom_range(0, 12)];
                set_prescale(p);
            end
            en = '1;
            if ($urandom_range(0, 3) == 0) en[$urandom_range(0, p - 1)] = 1'b0;
            drive_bit(p, {$urandom, $urandom}, en);
            if (i % 5 == 4 && p <= 60) begin
                for (int j = 0; j < 3; j++) begin
                    edge_cnt = 6'($urandom_range(p, 63));
                    enable = 1'b1; RX_IN = 1'($urandom);
                    @(posedge CLK);
                    #1;
                    total++;
                    if (sv !== 3'b000) $display("[TB] FAIL out_of_range_valid edge=%0d got=%b want=000", edge_cnt, sv);
                    else passed++;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_majority_p8();
        test_n5_p16();
        test_cfg_err();
        test_enable_drop();
        test_reset_midbit();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
